mux_n1_sched: RTL

Parametrised N:1 multiplexer with a registered output and valid/ready flow control on every input channel and on the output. Each cycle it selects one input channel, either by an explicit select or by round-robin over the requesting channels. It transfers that channel's word into a single output register. The block sits where several producers share one downstream consumer, and is the clocked, scalable counterpart of the team's 4:1 select mux.

---
 rtl/mux_n1_sched_if.sv | 36 +++
 rtl/mux_n1_sched.sv | 63 ++++++
 2 files changed

// File: rtl/mux_n1_sched_if.sv
// mux_n1_sched_if: input-channel and output handshake bundle for mux_n1_sched.
// y_par is present only when MUX_N1_SCHED_PARITY_EN is defined.
interface mux_n1_sched_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
);
    logic                     mode_in;
    logic [SEL_W-1:0]         sel_in;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH-1:0]        valid_in;
    logic [NUM_CH-1:0]        ready_out;
    logic [DATA_W-1:0]        y_data;
    logic [SEL_W-1:0]         y_ch;
    logic                     y_valid;
    logic                     y_ready;
`ifdef MUX_N1_SCHED_PARITY_EN
    logic                     y_par;
`endif

    modport master (
        output mode_in, sel_in, data_in, valid_in, y_ready,
`ifdef MUX_N1_SCHED_PARITY_EN
        input  y_par,
`endif
        input  ready_out, y_data, y_ch, y_valid
    );

    modport slave (
        input  mode_in, sel_in, data_in, valid_in, y_ready,
`ifdef MUX_N1_SCHED_PARITY_EN
        output y_par,
`endif
        output ready_out, y_data, y_ch, y_valid
    );
endinterface

// File: rtl/mux_n1_sched.sv
// mux_n1_sched: registered N:1 mux with per-channel valid/ready, fixed or round-robin select.
// Define MUX_N1_SCHED_PARITY_EN to add the y_par output.
module mux_n1_sched #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input logic clk,
    input logic rst_n,
    mux_n1_sched_if.slave bus
);
    logic [SEL_W-1:0]  ptr, grant, rr_grant, idx;
    logic              rr_vld, grant_vld, load_en, xfer;
    logic [DATA_W-1:0] grant_data;

    assign load_en = !bus.y_valid || bus.y_ready;

    // Scan downward so the smallest offset past ptr (next in rotation) wins.
    always_comb begin
        rr_grant = '0;
        rr_vld = 1'b0;
        idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = SEL_W'((int'(ptr) + k) % NUM_CH);
            if (bus.valid_in[idx]) begin
                rr_grant = idx;
                rr_vld = 1'b1;
            end
        end
    end

    always_comb begin
        grant = bus.mode_in ? rr_grant : bus.sel_in;
        grant_vld = bus.mode_in ? rr_vld : (int'(bus.sel_in) < NUM_CH) && bus.valid_in[bus.sel_in];
        xfer = rst_n && load_en && grant_vld;
        grant_data = bus.data_in[int'(grant)*DATA_W +: DATA_W];
    end

    assign bus.ready_out = xfer ? NUM_CH'(1) << grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SEL_W'(NUM_CH - 1);
            bus.y_valid <= 1'b0;
            bus.y_data <= '0;
            bus.y_ch <= '0;
        end else if (xfer) begin
            ptr <= grant;
            bus.y_valid <= 1'b1;
            bus.y_data <= grant_data;
            bus.y_ch <= grant;
        end else if (load_en) begin
            bus.y_valid <= 1'b0;
        end
    end

`ifdef MUX_N1_SCHED_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.y_par <= 1'b0;
        else if (xfer) bus.y_par <= ^grant_data;
    end
`endif
endmodule
